// File: rtl/sensor_serial_capture.sv
// rtl/sensor_serial_capture.sv - MSB-first serial capture of 4-bit sensor words with serial mod-5 remainder
// and a small output FIFO.
module sensor_serial_capture #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               bit_en,
  input  logic                               sdata,
  input  logic                               out_ready,
  output logic [3:0]                         sensor,
  output logic [2:0]                         rem_serial,
  output logic                               sensor_valid,
  output logic                               frame_err,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  shift_q, shift_d;
  logic [2:0]  r_q, r_d;
  logic        err_q, err_d;

  logic        push;
  logic [3:0]  push_word;
  logic [2:0]  r_step;

  logic [3:0]    mem_word_q [FIFO_DEPTH];
  logic [2:0]    mem_rem_q  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          overflow_q;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Remainder DFA: each incoming bit maps r to (2r + b) mod 5.
  always_comb begin
    r_step = 3'd0;
    case (r_q)
      3'd0:    r_step = sdata ? 3'd1 : 3'd0;
      3'd1:    r_step = sdata ? 3'd3 : 3'd2;
      3'd2:    r_step = sdata ? 3'd0 : 3'd4;
      3'd3:    r_step = sdata ? 3'd2 : 3'd1;
      3'd4:    r_step = sdata ? 3'd4 : 3'd3;
      default: r_step = 3'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!start && bit_en && (cnt_q == 2'd3)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A start inside a frame restarts it and flags the abort; it also beats a completing 4th bit.
  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    r_d       = r_q;
    err_d     = 1'b0;
    push      = 1'b0;
    push_word = {shift_q, sdata};
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = 2'd0;
          shift_d = 3'd0;
          r_d     = 3'd0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_d   = 2'd0;
          shift_d = 3'd0;
          r_d     = 3'd0;
          err_d   = 1'b1;
        end else if (bit_en) begin
          shift_d = {shift_q[1:0], sdata};
          r_d     = r_step;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            push = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 3'd0;
      r_q     <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign full  = (count_q == LW'(FIFO_DEPTH));
  assign pop   = sensor_valid & out_ready;
  assign wr_en = push & (~full | pop);

  // Storage is cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_word_q[i] <= 4'd0;
        mem_rem_q[i]  <= 3'd0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_word_q[wr_ptr_q] <= push_word;
        mem_rem_q[wr_ptr_q]  <= r_step;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
        count_q <= count_q + LW'(1);
      end else if (!wr_en && pop) begin
        count_q <= count_q - LW'(1);
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign sensor       = mem_word_q[rd_ptr_q];
  assign rem_serial   = mem_rem_q[rd_ptr_q];
  assign sensor_valid = (count_q != '0);
  assign level        = count_q;
  assign frame_err    = err_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_sensor_serial_capture.sv
// tb/tb_sensor_serial_capture.sv - scoreboard bench for sensor_serial_capture against a queue-based model.
module tb_sensor_serial_capture;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       bit_en;
  logic       sdata;
  logic       out_ready;
  logic [3:0] sensor;
  logic [2:0] rem_serial;
  logic       sensor_valid;
  logic       frame_err;
  logic       overflow;
  logic [2:0] level;

  sensor_serial_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bit_en       (bit_en),
    .sdata        (sdata),
    .out_ready    (out_ready),
    .sensor       (sensor),
    .rem_serial   (rem_serial),
    .sensor_valid (sensor_valid),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .level        (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mq[$];
  int pend[$];
  bit exp_ovf = 1'b0;
  bit err_flag = 1'b0;
  bit err_now = 1'b0;
  bit in_frame = 1'b0;
  int nbits = 0;
  int acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One input cycle; the model tracks frames purely as bit counts and integer accumulation.
  task automatic drive(input bit s, input bit be, input bit d);
    @(posedge clk);
    #1;
    start  = s;
    bit_en = be;
    sdata  = d;
    if (s) begin
      if (in_frame) err_flag = 1'b1;
      in_frame = 1'b1;
      nbits    = 0;
      acc      = 0;
    end else if (be && in_frame) begin
      acc = acc * 2 + int'(d);
      nbits++;
      if (nbits == 4) begin
        pend.push_back(acc);
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input int w, input int gap, input bit rdy_last);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'($urandom % 2));
      drive(1'b0, 1'b1, 1'((w >> (3 - i)) & 1));
      if (i == 3 && rdy_last) out_ready = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && (mq.size() > 0 || pend.size() > 0); i++) drive(1'b0, 1'b0, 1'b0);
    idle(2);
    chk("drain_level", int'(level), 0);
  endtask

  // Monitor: compare DUT against the model, then advance the model for the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid", int'(sensor_valid), int'(mq.size() > 0));
        chk("level", int'(level), mq.size());
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("frame_err", int'(frame_err), int'(err_now));
        if (mq.size() > 0) begin
          chk("head_word", int'(sensor), mq[0]);
          chk("head_rem", int'(rem_serial), mq[0] % 5);
        end
        err_now  = err_flag;
        err_flag = 1'b0;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (pend.size() > 0) begin
          int w;
          w = pend.pop_front();
          if (mq.size() == DEPTH) exp_ovf = 1'b1;
          else mq.push_back(w);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int words1[5];
    words1 = '{6, 13, 10, 3, 9};
    rst = 1'b1; start = 1'b0; bit_en = 1'b0; sdata = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sensor", int'(sensor), 0);
    chk("rst_rem", int'(rem_serial), 0);
    chk("rst_valid", int'(sensor_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_level", int'(level), 0);
    rst = 1'b0;
    idle(2);

    out_ready = 1'b1;
    foreach (words1[i]) send_frame(words1[i], 0, 1'b0);
    drain();

    send_frame(13, 2, 1'b0);
    drain();

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(int'($urandom % 16), 0, 1'b0);
    idle(2);
    send_frame(7, 0, 1'b1);
    drain();

    out_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(i, 0, 1'b0);
    idle(2);
    chk("ovf_level", int'(level), DEPTH);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_head", int'(sensor), 1);
    drain();

    out_ready = 1'b0;
    send_frame(4, 0, 1'b0);
    send_frame(11, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete(); pend.delete();
    exp_ovf = 1'b0; err_flag = 1'b0; err_now = 1'b0; in_frame = 1'b0;
    #1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_valid", int'(sensor_valid), 0);
    chk("mid_rst_sensor", int'(sensor), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    start = 1'b0; bit_en = 1'b0; sdata = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_frame(9, 0, 1'b0);
    drain();

    for (int i = 0; i < 2500; i++) begin
      drive(1'(($urandom % 100) < 8), 1'($urandom % 2), 1'($urandom % 2));
      out_ready = 1'(($urandom % 100) < 60);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_serial_capture.md
Name: sensor_serial_capture

Overview:
- Upstream stage of the mod-5 remainder datapath. Deserializes a framed, MSB-first serial sensor stream into 4-bit sensor words.
- Computes each word's remainder mod 5 on the fly with a serial DFA. The downstream combinational remainder block can be cross-checked against this result.
- Buffers word and remainder pairs in a small FIFO with a valid/ready output handshake.

Parameters:
- FIFO_DEPTH, 4, number of buffered words; power of two, at least 2.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start strobe; sdata ignored in this cycle.
- bit_en  in  1  qualifies sdata as a valid frame bit.
- sdata  in  1  serial sensor bit, MSB first.
- out_ready  in  1  downstream accepts the FIFO head.
- sensor  out  4  FIFO head word; this is the downstream block's sensor input.
- rem_serial  out  3  FIFO head remainder (sensor mod 5), range 0..4.
- sensor_valid  out  1  FIFO not empty.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, immediate): state=IDLE, bit count=0, shift register=0, running remainder=0, FIFO emptied.
  - Output values: sensor=0, rem_serial=0, sensor_valid=0, frame_err=0, overflow=0, level=0.
  - Reset mid-frame discards the partial word. Reset with a non-empty FIFO discards its contents.
- FSM states: IDLE, SHIFT.
  - IDLE: start=1 -> SHIFT, with bit count=0 and running remainder r=0. bit_en is ignored in IDLE.
  - SHIFT: on each cycle with bit_en=1 and start=0:
    - shift = {shift[2:0], sdata}
    - r = (2*r + sdata) mod 5, implemented as a 5-state DFA; never a divider.
    - bit count increments.
  - SHIFT with bit_en=0: hold all state.
  - On the 4th qualified bit: the completed word {shift[2:0], sdata} and the updated r are pushed to the FIFO on that same edge, and the FSM returns to IDLE.
  - start=1 while in SHIFT, regardless of bit_en:
    - frame_err pulses high for exactly the next cycle.
    - The partial word is discarded, and bit count and r are cleared.
    - The FSM stays in SHIFT, restarting the frame.
  - start on the same cycle as the 4th bit: start wins. The word is not pushed and frame_err pulses.
- Latency: a pushed word appears on sensor/rem_serial with sensor_valid=1 one cycle after the edge completing the frame, when the FIFO was empty.
- FIFO and handshake:
  - sensor, rem_serial, sensor_valid and level are registered or derived from FIFO pointers; no combinational path from the sdata input to any output.
  - Pop occurs when sensor_valid and out_ready are both 1 at the clock edge. Head data holds stable while sensor_valid=1 and out_ready=0.
  - Push when full with no pop: the word is dropped, overflow sets and remains 1 until reset, and FIFO contents are unchanged.
  - Push when full with a simultaneous pop: both are accepted; level stays FIFO_DEPTH.
  - Push and pop on the same cycle when empty is impossible, because pop requires valid. The push lands and level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head value when empty: sensor/rem_serial keep their last value and are don't-care; the bench checks them only when valid.
- Invariant: whenever sensor_valid=1, rem_serial == sensor mod 5.

Test Plan:
1. Frames 0110, 1101, 1010, 0011, 1001 (start, then 4 consecutive bit_en cycles each), out_ready=1 -> five heads in order with rem_serial 1, 3, 0, 3, 4; frame_err=0; overflow=0.
2. Frame 1101 with bit_en gaps of 2 idle cycles between bits -> single push of sensor=1101, rem_serial=3, one cycle after the 4th bit.
3. out_ready=0, push FIFO_DEPTH+1 frames (0001..0101) -> level=4, overflow=1, head=0001. Then out_ready=1 -> pops 0001, 0010, 0011, 0100 with rem 1, 2, 3, 4; 0101 is absent.
4. Start, bits 1,0, then start again, then bits 1,1,1,1 -> frame_err pulses once; single push of 1111 with rem_serial=0.
5. Full FIFO with out_ready=1 while a frame completes on the same cycle -> level stays 4, new word enqueued at the tail, overflow stays 0.
6. Assert rst mid-frame with 2 words queued -> outputs immediately 0 (level=0, valid=0). Next frame 1001 yields sensor=1001, rem_serial=4.
